// File: rtl/dbus_dma_pkg.sv
// dbus_dma_pkg: DBus widths, the all-lanes byte-enable constant and the
// copy-engine state encoding shared by the DMA and anything that decodes it.
package dbus_dma_pkg;

    localparam int DBUS_ADDR_W = 30;
    localparam int DBUS_DATA_W = 32;
    localparam logic [3:0] DBUS_BYTEEN_ALL = 4'hF;

    // Fixed 3-bit encodings so the state can be read off a debug probe.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } dmaState_t;

endpackage

// File: rtl/dbus_dma.sv
// dbus_dma: single-channel DBus initiator that copies a block of 32-bit words
// from a source word address to a destination word address, one word at a
// time in ascending order (read, capture, write: 3 cycles per word).
// Optional build macro DBUS_DMA_CHECKSUM_EN adds o_Checksum, the modulo-2^32
// sum of every word read during the current command.
module dbus_dma
    import dbus_dma_pkg::*;
#(
    parameter int LEN_BITS = 16
)
(
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Start,
    input  logic [DBUS_ADDR_W-1:0] i_SrcAddr,
    input  logic [DBUS_ADDR_W-1:0] i_DstAddr,
    input  logic [LEN_BITS-1:0]    i_Len,
    output logic                   o_Busy,
    output logic                   o_Done,
`ifdef DBUS_DMA_CHECKSUM_EN
    output logic [DBUS_DATA_W-1:0] o_Checksum,
`endif
    output logic [DBUS_ADDR_W-1:0] o_DBusAddr,
    output logic                   o_DBusRe,
    output logic                   o_DBusWe,
    output logic [3:0]             o_DBusByteEn,
    input  logic [DBUS_DATA_W-1:0] i_DBusRd,
    output logic [DBUS_DATA_W-1:0] o_DBusWd
);

    localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);
    localparam logic [DBUS_ADDR_W-1:0] ADDR_ONE = DBUS_ADDR_W'(1);

    dmaState_t                state;
    logic [DBUS_ADDR_W-1:0]   srcReg;
    logic [DBUS_ADDR_W-1:0]   dstReg;
    logic [LEN_BITS-1:0]      countReg;
    logic [DBUS_DATA_W-1:0]   dataReg;
`ifdef DBUS_DMA_CHECKSUM_EN
    logic [DBUS_DATA_W-1:0]   csumReg;
`endif

    // Copy sequencer: state, address/count registers and the registered bus
    // strobes are all updated together so each output reflects the state it
    // belongs to, with no combinational path from any input.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state        <= IDLE;
            srcReg       <= '0;
            dstReg       <= '0;
            countReg     <= '0;
            dataReg      <= '0;
            o_Busy       <= 1'b0;
            o_Done       <= 1'b0;
            o_DBusAddr   <= '0;
            o_DBusRe     <= 1'b0;
            o_DBusWe     <= 1'b0;
            o_DBusByteEn <= 4'h0;
`ifdef DBUS_DMA_CHECKSUM_EN
            csumReg      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        srcReg   <= i_SrcAddr;
                        dstReg   <= i_DstAddr;
                        countReg <= i_Len;
                        o_Busy   <= 1'b1;
`ifdef DBUS_DMA_CHECKSUM_EN
                        csumReg  <= '0;
`endif
                        if (i_Len == '0) begin
                            // Empty command: report completion without touching the bus.
                            state  <= DONE;
                            o_Done <= 1'b1;
                        end else begin
                            state      <= RD;
                            o_DBusAddr <= i_SrcAddr;
                            o_DBusRe   <= 1'b1;
                        end
                    end
                end

                RD: begin
                    // Address stays on the source word while the slave returns data.
                    state    <= CAP;
                    o_DBusRe <= 1'b0;
                end

                CAP: begin
                    dataReg      <= i_DBusRd;
`ifdef DBUS_DMA_CHECKSUM_EN
                    csumReg      <= csumReg + i_DBusRd;
`endif
                    state        <= WR;
                    o_DBusAddr   <= dstReg;
                    o_DBusWe     <= 1'b1;
                    o_DBusByteEn <= DBUS_BYTEEN_ALL;
                end

                WR: begin
                    // Addresses wrap modulo 2^30 naturally through the register width.
                    srcReg       <= srcReg + ADDR_ONE;
                    dstReg       <= dstReg + ADDR_ONE;
                    countReg     <= countReg - LEN_ONE;
                    o_DBusWe     <= 1'b0;
                    o_DBusByteEn <= 4'h0;
                    if (countReg == LEN_ONE) begin
                        state      <= DONE;
                        o_Done     <= 1'b1;
                        o_DBusAddr <= '0;
                    end else begin
                        state      <= RD;
                        o_DBusAddr <= srcReg + ADDR_ONE;
                        o_DBusRe   <= 1'b1;
                    end
                end

                DONE: begin
                    // Start requests seen here are dropped; the next one is taken in IDLE.
                    state  <= IDLE;
                    o_Done <= 1'b0;
                    o_Busy <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    o_Busy       <= 1'b0;
                    o_Done       <= 1'b0;
                    o_DBusAddr   <= '0;
                    o_DBusRe     <= 1'b0;
                    o_DBusWe     <= 1'b0;
                    o_DBusByteEn <= 4'h0;
                end
            endcase
        end
    end

    // Write data is only presented while the write strobe is up.
    assign o_DBusWd = o_DBusWe ? dataReg : '0;

`ifdef DBUS_DMA_CHECKSUM_EN
    assign o_Checksum = csumReg;
`endif

endmodule

// File: tb/tb_dbus_dma.sv
// tb_dbus_dma: self-checking bench for dbus_dma with two bus RAM slaves.
// Build with DBUS_DMA_CHECKSUM_EN defined to also exercise o_Checksum.
module tb_dbus_dma;

    localparam int LEN_BITS = 16;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Start = 1'b0;
    logic [29:0] i_SrcAddr = '0;
    logic [29:0] i_DstAddr = '0;
    logic [15:0] i_Len = '0;
    logic        o_Busy, o_Done;
    logic [29:0] o_DBusAddr;
    logic        o_DBusRe, o_DBusWe;
    logic [3:0]  o_DBusByteEn;
    logic [31:0] i_DBusRd;
    logic [31:0] o_DBusWd;
`ifdef DBUS_DMA_CHECKSUM_EN
    logic [31:0] o_Checksum;
`endif

    dbus_dma #(.LEN_BITS(LEN_BITS)) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Start      (i_Start),
        .i_SrcAddr    (i_SrcAddr),
        .i_DstAddr    (i_DstAddr),
        .i_Len        (i_Len),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
`ifdef DBUS_DMA_CHECKSUM_EN
        .o_Checksum   (o_Checksum),
`endif
        .o_DBusAddr   (o_DBusAddr),
        .o_DBusRe     (o_DBusRe),
        .o_DBusWe     (o_DBusWe),
        .o_DBusByteEn (o_DBusByteEn),
        .i_DBusRd     (i_DBusRd),
        .o_DBusWd     (o_DBusWd)
    );

    always #5 i_Clk = ~i_Clk;

    // ---------------- RAM block 0 (addr[6]=0) and RAM block 1 (addr[6]=1)
    logic [31:0] ram0 [0:63];
    logic [31:0] ram1 [0:63];
    logic        loadRam = 1'b1;

    function automatic logic [31:0] initWord(input int idx);
        if (idx < 4)  return 32'h11111111 * 32'(idx + 1);
        if (idx == 8) return 32'hFFFFFFFF;
        if (idx == 9) return 32'h00000002;
        return 32'hC0DE0000 | 32'(idx);
    endfunction

    function automatic int ix(input logic [29:0] a);
        return int'({a[6], a[5:0]});
    endfunction

    always @(posedge i_Clk) begin
        if (loadRam) begin
            for (int i = 0; i < 64; i++) begin
                ram0[i] <= initWord(i);
                ram1[i] <= initWord(64 + i);
            end
        end else if (o_DBusWe) begin
            if (o_DBusAddr[6]) ram1[o_DBusAddr[5:0]] <= o_DBusWd;
            else               ram0[o_DBusAddr[5:0]] <= o_DBusWd;
        end
        if (o_DBusRe)
            i_DBusRd <= o_DBusAddr[6] ? ram1[o_DBusAddr[5:0]] : ram0[o_DBusAddr[5:0]];
    end

    function automatic logic [31:0] ramWord(input logic [29:0] a);
        return a[6] ? ram1[a[5:0]] : ram0[a[5:0]];
    endfunction

    // ---------------- model memory and scoreboard
    logic [31:0] mdl [0:127];
    typedef struct packed { logic [29:0] addr; logic [31:0] data; } wr_t;
    wr_t         wrQ[$];
    logic [29:0] rdQ[$];

    int checks = 0, passes = 0;
    int reCnt = 0, weCnt = 0, doneCnt = 0;
    logic [29:0] lastReAddr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic modelCopy(input logic [29:0] src, input logic [29:0] dst, input int len);
        wr_t w;
        logic [29:0] s, d;
        for (int i = 0; i < len; i++) begin
            s = src + 30'(i);
            d = dst + 30'(i);
            rdQ.push_back(s);
            w.addr = d;
            w.data = mdl[ix(s)];
            wrQ.push_back(w);
            mdl[ix(d)] = mdl[ix(s)];
        end
    endtask

    // Bus monitor: every strobe must match the next expected scoreboard entry.
    always @(negedge i_Clk) begin
        wr_t w;
        if (o_DBusRe === 1'b1) begin
            reCnt++;
            lastReAddr = o_DBusAddr;
            chk("rd_pending", 64'(rdQ.size() != 0), 64'd1);
            if (rdQ.size() != 0) chk("rd_addr", 64'(o_DBusAddr), 64'(rdQ.pop_front()));
            chk("rd_byteen", 64'(o_DBusByteEn), 64'd0);
        end
        if (o_DBusWe === 1'b1) begin
            weCnt++;
            chk("wr_pending", 64'(wrQ.size() != 0), 64'd1);
            if (wrQ.size() != 0) begin
                w = wrQ.pop_front();
                chk("wr_addr", 64'(o_DBusAddr), 64'(w.addr));
                chk("wr_data", 64'(o_DBusWd), 64'(w.data));
                $display("write addr=0x%08h data=0x%08h", o_DBusAddr, o_DBusWd);
            end
            chk("wr_byteen", 64'(o_DBusByteEn), 64'hF);
        end
        if (o_Done === 1'b1) doneCnt++;
    end

    // ---------------- stimulus helpers
    task automatic issue(input logic [29:0] src, input logic [29:0] dst, input int len);
        @(posedge i_Clk); #1;
        i_Start = 1'b1; i_SrcAddr = src; i_DstAddr = dst; i_Len = 16'(len);
        @(posedge i_Clk); #1;
        i_Start = 1'b0; i_SrcAddr = 30'($urandom); i_DstAddr = 30'($urandom); i_Len = 16'($urandom);
    endtask

    task automatic waitDone(output int n, output int busy);
        bit got = 0;
        n = 0; busy = 0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge i_Clk);
            n++;
            if (o_Busy) busy++;
            if (o_Done) got = 1;
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic runCheck(input logic [29:0] src, input logic [29:0] dst, input int len,
                            input int expDone);
        int n, b;
        reCnt = 0; weCnt = 0;
        modelCopy(src, dst, len);
        issue(src, dst, len);
        waitDone(n, b);
        chk("done_latency", 64'(n), 64'(expDone));
        chk("busy_cycles", 64'(b), 64'(expDone));
        chk("re_count", 64'(reCnt), 64'(len));
        chk("we_count", 64'(weCnt), 64'(len));
        @(negedge i_Clk);
        chk("busy_after_done", 64'(o_Busy), 64'd0);
        chk("queues_drained", 64'(rdQ.size() + wrQ.size()), 64'd0);
        for (int i = 0; i < len; i++)
            chk("dst_word", 64'(ramWord(dst + 30'(i))), 64'(mdl[ix(dst + 30'(i))]));
        $display("copy src=0x%08h dst=0x%08h len=%0d done_after=%0d", src, dst, len, n);
    endtask

    typedef struct {
        logic [29:0] src;
        logic [29:0] dst;
        int          len;
        int          expDone;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b, doneBefore;
        logic [29:0] rs, rd;
        logic [31:0] oldWord;
        wr_t w;

        for (int i = 0; i < 128; i++) mdl[i] = initWord(i);

        vecs[0] = '{30'h00, 30'h40, 4, 13};
        vecs[1] = '{30'h02, 30'h44, 3, 10};
        vecs[2] = '{30'h10, 30'h12, 3, 10};   // overlapping, ascending order
        vecs[3] = '{30'h20, 30'h50, 0, 1};    // empty command
        vecs[4] = '{30'h31, 30'h3F, 1, 4};

        // Reset state
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        chk("rst_busy", 64'(o_Busy), 64'd0);
        chk("rst_done", 64'(o_Done), 64'd0);
        chk("rst_addr", 64'(o_DBusAddr), 64'd0);
        chk("rst_re", 64'(o_DBusRe), 64'd0);
        chk("rst_we", 64'(o_DBusWe), 64'd0);
        chk("rst_byteen", 64'(o_DBusByteEn), 64'd0);
        chk("rst_wd", 64'(o_DBusWd), 64'd0);
`ifdef DBUS_DMA_CHECKSUM_EN
        chk("rst_csum", 64'(o_Checksum), 64'd0);
`endif
        @(posedge i_Clk); #1;
        i_Rst = 1'b0; loadRam = 1'b0;

        // Table-driven copies
        for (int v = 0; v < 5; v++)
            runCheck(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].expDone);

        // Start pulsed mid-transfer with other addresses must be ignored
        doneCnt = 0; weCnt = 0;
        oldWord = mdl[ix(30'h60)];
        modelCopy(30'h04, 30'h58, 4);
        issue(30'h04, 30'h58, 4);
        repeat (4) @(negedge i_Clk);
        issue(30'h20, 30'h60, 2);
        waitDone(n, b);
        repeat (4) @(negedge i_Clk);
        chk("mid_done_count", 64'(doneCnt), 64'd1);
        chk("mid_we_count", 64'(weCnt), 64'd4);
        chk("mid_queues", 64'(rdQ.size() + wrQ.size()), 64'd0);
        for (int i = 0; i < 4; i++)
            chk("mid_dst_word", 64'(ramWord(30'h58 + 30'(i))), 64'(mdl[ix(30'h58 + 30'(i))]));
        chk("mid_other_dst", 64'(ramWord(30'h60)), 64'(oldWord));
        $display("mid-transfer start ignored, done_count=%0d", doneCnt);

        // Reset in place of the 2nd write of a 4-word copy
        doneCnt = 0;
        rs = 30'h30; rd = 30'h68;
        oldWord = mdl[ix(rd + 30'd1)];
        rdQ.push_back(rs);
        rdQ.push_back(rs + 30'd1);
        w.addr = rd; w.data = mdl[ix(rs)];
        wrQ.push_back(w);
        mdl[ix(rd)] = mdl[ix(rs)];
        issue(rs, rd, 4);
        repeat (4) @(negedge i_Clk);
        @(posedge i_Clk); #1;
        i_Rst = 1'b1;
        @(posedge i_Clk);
        @(negedge i_Clk);
        chk("abort_busy", 64'(o_Busy), 64'd0);
        chk("abort_done", 64'(o_Done), 64'd0);
        chk("abort_addr", 64'(o_DBusAddr), 64'd0);
        chk("abort_re", 64'(o_DBusRe), 64'd0);
        chk("abort_we", 64'(o_DBusWe), 64'd0);
        chk("abort_byteen", 64'(o_DBusByteEn), 64'd0);
        chk("abort_wd", 64'(o_DBusWd), 64'd0);
        @(posedge i_Clk); #1;
        i_Rst = 1'b0;
        repeat (6) @(negedge i_Clk);
        chk("abort_no_done", 64'(doneCnt), 64'd0);
        chk("abort_queues", 64'(rdQ.size() + wrQ.size()), 64'd0);
        chk("abort_dst0", 64'(ramWord(rd)), 64'(mdl[ix(rd)]));
        chk("abort_dst1", 64'(ramWord(rd + 30'd1)), 64'(oldWord));
        $display("reset abort checked, dst1=0x%08h", ramWord(rd + 30'd1));
        runCheck(30'h30, 30'h6C, 2, 7);

        // Source address wrap at the top of the 30-bit space
        runCheck(30'h3FFFFFFF, 30'h70, 2, 7);
        chk("wrap_second_read", 64'(lastReAddr), 64'd0);

`ifdef DBUS_DMA_CHECKSUM_EN
        // Checksum: 0xFFFFFFFF + 2 wraps to 1, then a back-to-back command clears it
        modelCopy(30'h08, 30'h74, 2);
        issue(30'h08, 30'h74, 2);
        waitDone(n, b);
        chk("csum_first", 64'(o_Checksum), 64'h1);
        modelCopy(30'h00, 30'h78, 1);
        issue(30'h00, 30'h78, 1);
        @(negedge i_Clk);
        chk("csum_cleared", 64'(o_Checksum), 64'h0);
        waitDone(n, b);
        chk("csum_second_latency", 64'(n + 1), 64'd4);
        repeat (2) @(negedge i_Clk);
        chk("csum_hold", 64'(o_Checksum), 64'h11111111);
        chk("csum_queues", 64'(rdQ.size() + wrQ.size()), 64'd0);
        $display("checksum after second command=0x%08h", o_Checksum);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
